// File: rtl/bp_fpga_host_pkg.sv
// bp_fpga_host_pkg: shared state enum, BedRock IO message types and putchar address
package bp_fpga_host_pkg;
  localparam int paddr_width_gp = 40;
  localparam int data_width_gp = 64;
  localparam int payload_width_gp = 16;
  localparam logic [paddr_width_gp-1:0] putchar_addr_gp = 40'h0010_1000;
  typedef enum logic [1:0] {e_idle, e_send, e_wait, e_error} io_cmd_gen_state_e;
  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_amo   = 4'd4
  } bp_bedrock_mem_type_e;
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;
  typedef struct packed {
    bp_bedrock_mem_type_e mem;
  } bp_bedrock_msg_type_s;
  typedef struct packed {
    logic [payload_width_gp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_gp-1:0]   addr;
    bp_bedrock_msg_type_s        msg_type;
  } bp_bedrock_io_mem_header_s;
  typedef struct packed {
    logic [data_width_gp-1:0]  data;
    bp_bedrock_io_mem_header_s header;
  } bp_bedrock_io_mem_msg_s;
  localparam int io_mem_msg_width_lp = $bits(bp_bedrock_io_mem_msg_s);
endpackage

// File: rtl/bsg_debounce_edge.sv
// bsg_debounce_edge: synchronize a raw level, debounce it and pulse on its accepted rising edge
module bsg_debounce_edge #(
  parameter int cycles_p = 1000000
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic i,
  output logic rise_o
);
  localparam int cw_lp = $clog2(cycles_p + 1);
  logic [1:0] sync_r;
  logic stable_r, hit;
  logic [cw_lp-1:0] cnt_r;
  assign hit = (sync_r[1] != stable_r) && (cnt_r == cw_lp'(cycles_p - 1));
  // count how long the synchronized level has disagreed with the stable level; accept after cycles_p
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      sync_r   <= '0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
      rise_o   <= 1'b0;
    end else begin
      sync_r   <= {sync_r[0], i};
      cnt_r    <= (sync_r[1] == stable_r || hit) ? '0 : cnt_r + 1'b1;
      stable_r <= hit ? sync_r[1] : stable_r;
      rise_o   <= hit & sync_r[1];
    end
endmodule

// File: rtl/bp_fpga_host_io_cmd_gen.sv
// bp_fpga_host_io_cmd_gen: button-driven putchar uncached-write source with response checking
module bp_fpga_host_io_cmd_gen
  import bp_fpga_host_pkg::*;
#(
  parameter logic [paddr_width_gp-1:0] putchar_addr_p = putchar_addr_gp,
  parameter int debounce_cycles_p = 1000000,
  parameter int resp_timeout_p = 65536,
  parameter logic [7:0] init_byte_p = 8'h41
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           send_i,
  output logic [io_mem_msg_width_lp-1:0] io_cmd_o,
  output logic                           io_cmd_v_o,
  input  logic                           io_cmd_ready_and_i,
  input  logic [io_mem_msg_width_lp-1:0] io_resp_i,
  input  logic                           io_resp_v_i,
  output logic                           io_resp_yumi_o,
  output logic                           busy_o,
  output logic                           error_o,
  output logic [15:0]                    sent_count_o
);
  localparam int tw_lp = $clog2(resp_timeout_p + 1);
  io_cmd_gen_state_e state_r, state_n;
  bp_bedrock_io_mem_msg_s cmd, resp;
  logic press, pending_r, err_set, ok, done, unused_resp;
  logic [7:0] data_byte_r;
  logic [tw_lp-1:0] tmr_r;
  assign resp = io_resp_i;
  assign unused_resp = ^{resp.data, resp.header.size, resp.header.payload};
  assign ok = (resp.header.msg_type.mem == e_bedrock_mem_uc_wr) && (resp.header.addr == putchar_addr_p);
  assign done = (state_r == e_wait) && io_resp_v_i && ok;
  assign busy_o = (state_r == e_send) || (state_r == e_wait);
  assign io_cmd_o = cmd;
  bsg_debounce_edge #(.cycles_p(debounce_cycles_p)) db (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .i(send_i),
    .rise_o(press)
  );
  // putchar command: every byte lane carries the current character
  always_comb begin
    cmd = '0;
    cmd.header.msg_type.mem = e_bedrock_mem_uc_wr;
    cmd.header.addr = putchar_addr_p;
    cmd.header.size = e_bedrock_msg_size_1;
    cmd.data = {8{data_byte_r}};
  end
  // next state and handshakes; any response outside e_wait is unexpected and fatal
  always_comb begin
    state_n = state_r;
    io_cmd_v_o = 1'b0;
    io_resp_yumi_o = io_resp_v_i;
    err_set = 1'b0;
    case (state_r)
      e_idle: begin
        err_set = io_resp_v_i;
        state_n = io_resp_v_i ? e_error : pending_r ? e_send : e_idle;
      end
      e_send: begin
        io_cmd_v_o = 1'b1;
        err_set = io_resp_v_i;
        state_n = io_resp_v_i ? e_error : io_cmd_ready_and_i ? e_wait : e_send;
      end
      e_wait: begin
        err_set = io_resp_v_i ? !ok : (tmr_r == tw_lp'(resp_timeout_p - 1));
        state_n = err_set ? e_error : io_resp_v_i ? e_idle : e_wait;
      end
      e_error: state_n = e_error;
      default: begin
        err_set = 1'b1;
        state_n = e_error;
      end
    endcase
  end
  // state, one-deep press queue, character, completion count, sticky error and response timer
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      state_r      <= e_idle;
      pending_r    <= 1'b0;
      data_byte_r  <= init_byte_p;
      sent_count_o <= '0;
      error_o      <= 1'b0;
      tmr_r        <= '0;
    end else begin
      state_r      <= state_n;
      pending_r    <= (state_r == e_idle && pending_r) ? 1'b0 : pending_r | (press && state_r != e_error);
      data_byte_r  <= data_byte_r + 8'(done);
      sent_count_o <= sent_count_o + 16'(done);
      error_o      <= error_o | err_set;
      tmr_r        <= (state_r == e_wait) ? tmr_r + 1'b1 : '0;
    end
endmodule
